// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per cycle.
// Produces a one-cycle result pulse with BCD digits, leading-zero blank mask and overflow flag.
module bin2bcd_seq #(
  parameter int DW = 8,
  parameter int ND = 3
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [DW-1:0]     iDAT,
  output logic              oREADY,
  output logic              oVALID,
  output logic [4*ND-1:0]   oBCD,
  output logic [ND-1:0]     oBLANK,
  output logic              oOVF
);

  // Internal digit count: ceil(DW*log10(2)) + 1, never fewer than the output digits.
  localparam int NI_RAW = (DW * 30103 + 99999) / 100000 + 1;
  localparam int NI     = (NI_RAW > ND) ? NI_RAW : ND;
  localparam int CW     = $clog2(DW + 1);
  localparam logic [ND-1:0] BLANK_RST = ~ND'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       sr;
  logic [4*NI-1:0]     scr;
  logic [CW-1:0]       cnt;
  logic                accept, shift_en, done, last_step;

  function automatic logic [4*NI+DW-1:0] dabble_step(input logic [4*NI-1:0] s,
                                                     input logic [DW-1:0]   b);
    logic [4*NI-1:0] adj;
    adj = s;
    for (int i = 0; i < NI; i++) begin
      if (s[4*i +: 4] >= 4'd5) adj[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return {adj, b} << 1;
  endfunction

  function automatic logic upper_nonzero(input logic [4*NI-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = ND; i < NI; i++) begin
      r = r | (s[4*i +: 4] != 4'd0);
    end
    return r;
  endfunction

  // Bit i set when digits i..ND-1 are all zero; the units digit is always shown.
  function automatic logic [ND-1:0] blank_mask(input logic [4*ND-1:0] d);
    logic [ND-1:0] m;
    logic          zero;
    m    = '0;
    zero = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      zero = zero & (d[4*i +: 4] == 4'd0);
      m[i] = zero;
    end
    return m;
  endfunction

  assign last_step = (cnt == CW'(DW - 1));

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iVALID) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oREADY   = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        oREADY = 1'b1;
        accept = iVALID;
      end
      SHIFT:   shift_en = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath: load on accept, one dabble step per SHIFT cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sr  <= '0;
      scr <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= iDAT;
      scr <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      {scr, sr} <= dabble_step(scr, sr);
      cnt       <= cnt + CW'(1);
    end
  end

  // Result registers: updated only when leaving DONE, held otherwise.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oVALID <= 1'b0;
      oBCD   <= '0;
      oBLANK <= BLANK_RST;
      oOVF   <= 1'b0;
    end else begin
      oVALID <= done;
      if (done) begin
        oBCD   <= scr[4*ND-1:0];
        oBLANK <= blank_mask(scr[4*ND-1:0]);
        oOVF   <= upper_nonzero(scr);
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default (DW=8, ND=3) instance plus an ND=2 instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b;
  logic [7:0]  dat_a, dat_b;
  logic        ready_a, ready_b, ovalid_a, ovalid_b, ovf_a, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [2:0]  blank_a;
  logic [1:0]  blank_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {logic [11:0] bcd; logic [2:0] blank; logic ovf; int vcyc;} exp_a_t;
  typedef struct {logic [7:0] bcd; logic [1:0] blank; logic ovf; int vcyc;} exp_b_t;
  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;

  bin2bcd_seq #(.DW(8), .ND(3)) dut_a (
    .iCLK(clk), .iRST(rst), .iVALID(valid_a), .iDAT(dat_a),
    .oREADY(ready_a), .oVALID(ovalid_a), .oBCD(bcd_a), .oBLANK(blank_a), .oOVF(ovf_a)
  );

  bin2bcd_seq #(.DW(8), .ND(2)) dut_b (
    .iCLK(clk), .iRST(rst), .iVALID(valid_b), .iDAT(dat_b),
    .oREADY(ready_b), .oVALID(ovalid_b), .oBCD(bcd_b), .oBLANK(blank_b), .oOVF(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor for the ND=3 instance: compare each result against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ovalid_a) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_valid actual=1 required=0 cyc=%0d", cyc);
        end else begin
          ea = qa.pop_front();
          chk("a_bcd", 32'(bcd_a), 32'(ea.bcd));
          chk("a_blank", 32'(blank_a), 32'(ea.blank));
          chk("a_ovf", 32'(ovf_a), 32'(ea.ovf));
          chk("a_latency_cycle", 32'(cyc), 32'(ea.vcyc));
        end
      end else if (qa.size() != 0 && cyc > qa[0].vcyc) begin
        checks++; failures++;
        $display("FAIL a_missing_valid actual=none required_cycle=%0d", qa[0].vcyc);
        void'(qa.pop_front());
      end
    end
  end

  // Monitor for the ND=2 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ovalid_b) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_valid actual=1 required=0 cyc=%0d", cyc);
        end else begin
          eb = qb.pop_front();
          chk("b_bcd", 32'(bcd_b), 32'(eb.bcd));
          chk("b_blank", 32'(blank_b), 32'(eb.blank));
          chk("b_ovf", 32'(ovf_b), 32'(eb.ovf));
          chk("b_latency_cycle", 32'(cyc), 32'(eb.vcyc));
        end
      end else if (qb.size() != 0 && cyc > qb[0].vcyc) begin
        checks++; failures++;
        $display("FAIL b_missing_valid actual=none required_cycle=%0d", qb[0].vcyc);
        void'(qb.pop_front());
      end
    end
  end

  task automatic wait_ready_a();
    for (int t = 0; t < 40 && !ready_a; t++) @(negedge clk);
    chk("a_ready_before_send", 32'(ready_a), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] d, input logic [11:0] bcd,
                        input logic [2:0] blank, input logic ovf);
    wait_ready_a();
    valid_a = 1'b1;
    dat_a   = d;
    qa.push_back('{bcd: bcd, blank: blank, ovf: ovf, vcyc: cyc + 1 + 9});
    @(negedge clk);
    valid_a = 1'b0;
    drain();
  endtask

  task automatic send_b(input logic [7:0] d, input logic [7:0] bcd,
                        input logic [1:0] blank, input logic ovf);
    for (int t = 0; t < 40 && !ready_b; t++) @(negedge clk);
    chk("b_ready_before_send", 32'(ready_b), 32'd1);
    valid_b = 1'b1;
    dat_b   = d;
    qb.push_back('{bcd: bcd, blank: blank, ovf: ovf, vcyc: cyc + 1 + 9});
    @(negedge clk);
    valid_b = 1'b0;
    drain();
  endtask

  initial begin
    int k0;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; dat_a = '0; dat_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_valid", 32'(ovalid_a), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_blank", 32'(blank_a), 32'b110);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_blank_nd2", 32'(blank_b), 32'b10);
    mon_en = 1'b1;

    send_a(8'hFF, 12'h255, 3'b000, 1'b0);
    send_a(8'h09, 12'h009, 3'b110, 1'b0);
    send_a(8'h00, 12'h000, 3'b110, 1'b0);
    send_a(8'h64, 12'h100, 3'b000, 1'b0);
    send_a(8'h32, 12'h050, 3'b100, 1'b0);

    // Back-to-back with iVALID held high; iDAT scribbled while busy.
    wait_ready_a();
    k0 = cyc + 1;
    valid_a = 1'b1;
    dat_a   = 8'h0A;
    qa.push_back('{bcd: 12'h010, blank: 3'b100, ovf: 1'b0, vcyc: k0 + 9});
    @(negedge clk);
    dat_a = 8'hAA;
    chk("busy_ready_low", 32'(ready_a), 32'd0);
    while (cyc < k0 + 9) @(negedge clk);
    chk("tp_ready_2nd", 32'(ready_a), 32'd1);
    dat_a = 8'h1F;
    qa.push_back('{bcd: 12'h031, blank: 3'b100, ovf: 1'b0, vcyc: k0 + 19});
    @(negedge clk);
    dat_a = 8'h77;
    chk("busy_ready_low_2", 32'(ready_a), 32'd0);
    while (cyc < k0 + 19) @(negedge clk);
    chk("tp_ready_3rd", 32'(ready_a), 32'd1);
    dat_a = 8'hC8;
    qa.push_back('{bcd: 12'h200, blank: 3'b000, ovf: 1'b0, vcyc: k0 + 29});
    @(negedge clk);
    dat_a = 8'h11;
    while (cyc < k0 + 28) @(negedge clk);
    valid_a = 1'b0;
    drain();

    // Reset in mid-conversion discards the request.
    wait_ready_a();
    k0 = cyc + 1;
    valid_a = 1'b1;
    dat_a   = 8'h42;
    @(negedge clk);
    valid_a = 1'b0;
    while (cyc < k0 + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(ovalid_a), 32'd0);
    chk("abort_bcd", 32'(bcd_a), 32'd0);
    chk("abort_blank", 32'(blank_a), 32'b110);
    chk("abort_ovf", 32'(ovf_a), 32'd0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    repeat (14) @(negedge clk);
    send_a(8'h7B, 12'h123, 3'b000, 1'b0);

    send_b(8'hFF, 8'h55, 2'b00, 1'b1);
    send_b(8'h63, 8'h99, 2'b00, 1'b0);

    repeat (12) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
